// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
// Optional XOR checksum is enabled with FIFO_READER_CKSUM_EN.
package fifo_reader_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 8;
  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order valid/ready output buffer.
// Entry 0 is the head; push and pop may happen in the same cycle.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic              head_last
);

  logic [DATA_W-1:0] data_q [SKID_DEPTH];
  logic              last_q [SKID_DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              do_pop;
  logic              do_push;
  logic [CNT_W-1:0]  wr_idx;

  assign head_valid = (count_q != '0);
  assign do_pop     = pop && head_valid;
  assign do_push    = push &&
    ((count_q != CNT_W'(SKID_DEPTH)) || do_pop);
  assign wr_idx     = count_q - CNT_W'(do_pop);

  // Shift on pop first; a same-cycle push then
  // overwrites the slot it lands in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      count_q <= '0;
    end else begin
      if (do_pop) begin
        data_q[0] <= data_q[1];
        last_q[0] <= last_q[1];
        data_q[1] <= '0;
        last_q[1] <= 1'b0;
      end
      if (do_push) begin
        data_q[wr_idx[0]] <= push_data;
        last_q[wr_idx[0]] <= push_last;
      end
      count_q <= count_q
        + CNT_W'(do_push)
        - CNT_W'(do_pop);
    end
  end

  assign count     = count_q;
  assign head_data = data_q[0];
  assign head_last = last_q[0] && head_valid;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: pops cmd_len words from the FIFO onto a stream.
// Define FIFO_READER_CKSUM_EN to add the cksum/cksum_valid outputs.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              cmd_start,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              fifo_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef FIFO_READER_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum,
  output logic              cksum_valid
`endif
);

  localparam int OCC_W = CNT_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  sent;
  logic              inflight;
  logic [CNT_W-1:0]  skid_count;
  logic              pop;
  logic              start_ok;
  logic              push_last;
  logic [OCC_W-1:0]  occ;
  logic              room;
  logic              drained;

  assign start_ok = (state == IDLE) && cmd_start;
  assign pop      = out_valid && out_ready;
  assign fifo_en  = Rst_n;

  // Credit the word leaving this cycle so a steady
  // ready stream keeps one read per clock.
  assign occ  = OCC_W'(skid_count)
              + OCC_W'(inflight)
              - OCC_W'(pop);
  assign room = occ < OCC_W'(SKID_DEPTH);

  assign drained = !inflight &&
    ((skid_count == '0) ||
     ((skid_count == CNT_W'(1)) && pop));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_start) begin
          state_nxt = (cmd_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (fifo_rd && remaining == LEN_W'(1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // EMPTY already reflects the previous pop, so the
  // read strobe stays combinational from it.
  always_comb begin
    fifo_rd = 1'b0;
    busy    = (state != IDLE);
    done    = (state == DONE);
    if (state == READ) begin
      fifo_rd = !fifo_empty
             && (remaining != '0)
             && room;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      remaining <= '0;
      len_q     <= '0;
      sent      <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (start_ok) begin
        remaining <= cmd_len;
        len_q     <= cmd_len;
        sent      <= '0;
      end else begin
        if (fifo_rd) begin
          remaining <= remaining - LEN_W'(1);
        end
        if (inflight) begin
          sent <= sent + LEN_W'(1);
        end
      end
    end
  end

  assign push_last = (sent == len_q - LEN_W'(1));

  fifo_reader_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .push       (inflight),
    .push_data  (fifo_data),
    .push_last  (push_last),
    .pop        (pop),
    .count      (skid_count),
    .head_data  (out_data),
    .head_valid (out_valid),
    .head_last  (out_last)
  );

`ifdef FIFO_READER_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cksum_q <= '0;
    end else if (start_ok) begin
      cksum_q <= '0;
    end else if (pop) begin
      cksum_q <= cksum_q ^ out_data;
    end
  end

  assign cksum       = cksum_q;
  assign cksum_valid = done;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a small FIFO model.
// Checksum cases run when FIFO_READER_CKSUM_EN is defined.
module tb_fifo_stream_reader;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [7:0]  cmd_len = '0;
  logic        fifo_empty;
  logic [31:0] fifo_data = '0;
  logic        fifo_rd;
  logic        fifo_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef FIFO_READER_CKSUM_EN
  logic [31:0] cksum;
  logic        cksum_valid;
  logic [31:0] cks_seen = '0;
  logic        cv_seen = 1'b0;
`endif

  always #5 Clk = ~Clk;

  fifo_stream_reader dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .cmd_start  (cmd_start),
    .cmd_len    (cmd_len),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .fifo_en    (fifo_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef FIFO_READER_CKSUM_EN
    ,
    .cksum       (cksum),
    .cksum_valid (cksum_valid)
`endif
  );

  // FIFO model: combinational empty, registered dataOut
  logic [31:0] mem [16];
  int wp = 0;
  int rp = 0;

  assign fifo_empty = (wp == rp);

  always @(posedge Clk) begin
    if (fifo_rd && fifo_en && wp != rp) begin
      fifo_data <= mem[rp[3:0]];
      rp <= rp + 1;
    end
  end

  // Stream monitor, sampled mid-cycle
  int cyc = 0;
  int rd_cnt = 0;
  int acc_n = 0;
  int done_cyc = 0;
  int stab_err = 0;
  int max_ahead = 0;
  logic [31:0] acc_data [256];
  logic        acc_last [256];
  int          acc_cyc  [256];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge Clk) begin
    if (fifo_rd) rd_cnt++;
    if (prev_stall && (!out_valid || out_data != prev_data))
      stab_err++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      acc_data[acc_n[7:0]] = out_data;
      acc_last[acc_n[7:0]] = out_last;
      acc_cyc[acc_n[7:0]]  = cyc;
      acc_n++;
    end
    if (rd_cnt - acc_n > max_ahead) max_ahead = rd_cnt - acc_n;
    if (done) done_cyc = cyc;
    cyc++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] v);
    mem[wp[3:0]] = v;
    wp++;
  endtask

  task automatic start(input logic [7:0] len);
    @(posedge Clk); #1;
    cmd_start = 1'b1;
    cmd_len   = len;
    @(posedge Clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    logic got;
    k = 0;
    got = 1'b0;
    while (!got && k < 300) begin
      @(negedge Clk);
      k++;
      if (done) begin
        got = 1'b1;
`ifdef FIFO_READER_CKSUM_EN
        cks_seen = cksum;
        cv_seen  = cksum_valid;
`endif
      end
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
    @(negedge Clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic chk_outs_reset(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_last"},  64'(out_last),  64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_doneo"}, 64'(done),      64'd0);
    chk({tag, "_rd"},    64'(fifo_rd),   64'd0);
    chk({tag, "_data"},  64'(out_data),  64'd0);
  endtask

  initial begin
    int a0;
    int r0;
    int k;
    logic got;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [3:0]  ix;

    // reset state
    @(negedge Clk);
    @(negedge Clk);
    chk_outs_reset("rst");
    chk("rst_en", 64'(fifo_en), 64'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_en_hi", 64'(fifo_en), 64'd1);

    // five words at full rate
    for (int i = 1; i <= 5; i++) put(32'(i));
    a0 = acc_n;
    r0 = rd_cnt;
    start(8'd5);
    wait_done("t1");
    chk("t1_rd", 64'(rd_cnt - r0), 64'd5);
    chk("t1_n", 64'(acc_n - a0), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_d%0d", i), 64'(acc_data[a0 + i]), 64'(i + 1));
      chk($sformatf("t1_l%0d", i), 64'(acc_last[a0 + i]), 64'(i == 4));
    end
    chk("t1_b2b", 64'(acc_cyc[a0 + 4] - acc_cyc[a0]), 64'd4);
    chk("t1_dlat", 64'(done_cyc - acc_cyc[a0 + 4]), 64'd1);
`ifdef FIFO_READER_CKSUM_EN
    chk("t1_cks", 64'(cks_seen), 64'h1);
    chk("t1_cv", 64'(cv_seen), 64'd1);
`endif

    // partial read leaves words behind
    for (int i = 0; i < 8; i++) put(32'(i));
    a0 = acc_n;
    r0 = rd_cnt;
    start(8'd3);
    wait_done("t2");
    chk("t2_rd", 64'(rd_cnt - r0), 64'd3);
    chk("t2_lvl", 64'(wp - rp), 64'd5);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_d%0d", i), 64'(acc_data[a0 + i]), 64'(i));
      chk($sformatf("t2_l%0d", i), 64'(acc_last[a0 + i]), 64'(i == 2));
    end
    a0 = acc_n;
    start(8'd5);
    wait_done("t2b");
    chk("t2b_d4", 64'(acc_data[a0 + 4]), 64'd7);
    chk("t2b_empty", 64'(fifo_empty), 64'd1);

    // zero-length command
    r0 = rd_cnt;
    start(8'd0);
    wait_done("t0");
    chk("t0_rd", 64'(rd_cnt - r0), 64'd0);
`ifdef FIFO_READER_CKSUM_EN
    chk("t0_cks", 64'(cks_seen), 64'h0);
    chk("t0_cv", 64'(cv_seen), 64'd1);
`endif

    // backpressure with ready pattern 1,0,0
    for (int i = 0; i < 4; i++) put(32'hA0 + 32'(i * 16));
    a0 = acc_n;
    r0 = stab_err;
    start(8'd4);
    k = 0;
    got = 1'b0;
    while (!got && k < 300) begin
      out_ready = (k % 3 == 0);
      @(negedge Clk);
      if (done) got = 1'b1;
      @(posedge Clk); #1;
      k++;
    end
    out_ready = 1'b1;
    chk("t3_done", 64'(got), 64'd1);
    chk("t3_n", 64'(acc_n - a0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_d%0d", i), 64'(acc_data[a0 + i]),
          64'(32'hA0 + 32'(i * 16)));
    end
    chk("t3_last", 64'(acc_last[a0 + 3]), 64'd1);
    chk("t3_last2", 64'(acc_last[a0 + 2]), 64'd0);
    chk("t3_stable", 64'(stab_err - r0), 64'd0);
    chk("t3_ahead", 64'(max_ahead <= 2), 64'd1);

    // empty FIFO stall
    a0 = acc_n;
    r0 = rd_cnt;
    start(8'd3);
    repeat (10) @(negedge Clk);
    chk("t4_stall_rd", 64'(rd_cnt - r0), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    @(posedge Clk); #1;
    put(32'h100);
    put(32'h200);
    put(32'h300);
    wait_done("t4");
    chk("t4_rd", 64'(rd_cnt - r0), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_d%0d", i), 64'(acc_data[a0 + i]),
          64'(32'h100 * (i + 1)));
    end

    // reset mid-transfer
    for (int i = 1; i <= 6; i++) put(32'hC0 + 32'(i));
    a0 = acc_n;
    start(8'd6);
    k = 0;
    while (acc_n - a0 < 2 && k < 100) begin
      @(negedge Clk);
      k++;
    end
    chk("t5_two", 64'(acc_n - a0 >= 2), 64'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_outs_reset("t5");
    @(negedge Clk);
    #2;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("t5_idle", 64'(busy), 64'd0);
    ix = rp[3:0];
    e0 = mem[ix];
    ix = ix + 4'd1;
    e1 = mem[ix];
    a0 = acc_n;
    start(8'd2);
    wait_done("t5");
    chk("t5_n", 64'(acc_n - a0), 64'd2);
    chk("t5_d0", 64'(acc_data[a0]), 64'(e0));
    chk("t5_d1", 64'(acc_data[a0 + 1]), 64'(e1));
    chk("t5_l1", 64'(acc_last[a0 + 1]), 64'd1);

`ifdef FIFO_READER_CKSUM_EN
    // checksum of complementary nibbles
    @(posedge Clk); #1;
    wp = rp;
    put(32'h0F);
    put(32'hF0);
    put(32'hFF);
    start(8'd3);
    wait_done("t6");
    chk("t6_cks", 64'(cks_seen), 64'h0);
    chk("t6_cv", 64'(cv_seen), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
